// File: rtl/dii_package.sv
// Shared debug-interconnect flit definitions, destination width and the
// arbiter state type used by the ring router.
package dii_package;

  localparam int DII_DATA_WIDTH = 16;
  localparam int DII_DEST_WIDTH = 10;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_flit;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // True when a destination ID belongs to one of the local ports.
  function automatic logic destIsLocal(input logic [DII_DEST_WIDTH-1:0] dest,
                                       input int baseId, input int ports);
    int d;
    d = int'(dest);
    return (d >= baseId) && (d < baseId + ports);
  endfunction

endpackage

// File: rtl/dii_buffer.sv
// Small flit FIFO; head is presented combinationally, ready drops when full.
module dii_buffer
  import dii_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit i_flit,
  output logic    o_inReady,
  output dii_flit o_flit,
  input  logic    i_outReady
);

  localparam int AW = $clog2(DEPTH);

  logic [DII_DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wrPtr;
  logic [AW-1:0]           r_rdPtr;
  logic [AW:0]             r_count;
  logic                    w_push;
  logic                    w_pop;

  assign o_inReady    = (r_count != (AW+1)'(DEPTH));
  assign w_push       = i_flit.valid & o_inReady;
  assign o_flit.valid = (r_count != '0);
  assign o_flit.last  = r_mem[r_rdPtr][DII_DATA_WIDTH];
  assign o_flit.data  = r_mem[r_rdPtr][DII_DATA_WIDTH-1:0];
  assign w_pop        = o_flit.valid & i_outReady;

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Flit storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {i_flit.last, i_flit.data};
  end

endmodule

// File: rtl/osd_rr_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: a winner keeps the output until its
// last flit transfers; the search pointer moves only when a packet completes.
module osd_rr_pkt_arbiter
  import dii_package::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last,
  input  logic         i_ready,
  output logic [N-1:0] o_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_e r_state, w_stateNext;
  logic [IW-1:0] r_ptr, r_owner, w_ptrNext, w_ownerNext, w_pick, w_sel;
  logic          w_pickValid;
  logic          w_xfer;
  logic          w_xferLast;

  // State, owner and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_owner <= w_ownerNext;
    end
  end

  // Grant: locked owner, or the first requester at or after the pointer.
  always_comb begin
    w_pick      = '0;
    w_pickValid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        w_pick      = IW'(j);
        w_pickValid = 1'b1;
      end
    end
    w_sel   = (r_state == ARB_LOCKED) ? r_owner : w_pick;
    o_grant = '0;
    if (r_state == ARB_LOCKED || w_pickValid) o_grant[w_sel] = 1'b1;
  end

  assign w_xfer     = (|(o_grant & i_req)) & i_ready;
  assign w_xferLast = w_xfer & i_last[w_sel];

  // Lock on a non-final flit, release and advance past the winner on the last.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    if (w_xferLast) begin
      w_stateNext = ARB_IDLE;
      w_ptrNext   = (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
    end else if (w_xfer) begin
      w_stateNext = ARB_LOCKED;
      w_ownerNext = w_sel;
    end
  end

endmodule

// File: rtl/osd_ring_router.sv
// Ring router: buffers each ring input, delivers packets addressed to local
// ports, forwards the rest, and injects local packets onto ring 0.
module osd_ring_router
  import dii_package::*;
#(
  parameter int PORTS     = 4,
  parameter int RINGS     = 2,
  parameter int BASE_ID   = 0,
  parameter int BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  dii_flit [RINGS-1:0]    ring_in,
  output logic    [RINGS-1:0]    ring_in_ready,
  output dii_flit [RINGS-1:0]    ring_out,
  input  logic    [RINGS-1:0]    ring_out_ready,
  input  dii_flit [PORTS-1:0]    dii_in,
  output logic    [PORTS-1:0]    dii_in_ready,
  output dii_flit [PORTS-1:0]    dii_out,
  input  logic    [PORTS-1:0]    dii_out_ready
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (BASE_ID < 0 || BASE_ID + PORTS > 1024) begin : g_badBaseId
    $error("osd_ring_router: local IDs must lie within 0..1023");
  end
  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_badDepth
    $error("osd_ring_router: BUF_DEPTH must be a power of two >= 2");
  end

  logic                 r_active;
  dii_flit [RINGS-1:0]  w_head;
  logic    [RINGS-1:0]  w_fifoReady, w_headPop, w_local, w_fwdReq, w_fwdGrant;
  logic    [RINGS-1:0]  r_inPkt, r_routeLocal;
  logic    [PW-1:0]     r_routePort [RINGS];
  logic    [PW-1:0]     w_port      [RINGS];
  logic    [PORTS-1:0]  w_locReq    [RINGS];
  logic    [RINGS-1:0]  w_locGrant  [PORTS];

  // Holds inputs off for the first cycle after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_active <= 1'b0;
    else     r_active <= 1'b1;
  end

  for (genvar r = 0; r < RINGS; r++) begin : g_ringIn
    dii_flit w_inMasked;
    assign w_inMasked = {ring_in[r].valid & r_active, ring_in[r].last, ring_in[r].data};
    assign ring_in_ready[r] = w_fifoReady[r] & r_active;
    dii_buffer #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flit     (w_inMasked),
      .o_inReady  (w_fifoReady[r]),
      .o_flit     (w_head[r]),
      .i_outReady (w_headPop[r])
    );
  end

  // Route of each head flit: decoded on the first flit, held mid-packet.
  always_comb begin
    for (int r = 0; r < RINGS; r++) begin
      w_local[r] = r_inPkt[r] ? r_routeLocal[r]
                              : destIsLocal(w_head[r].data[DII_DEST_WIDTH-1:0], BASE_ID, PORTS);
      w_port[r]  = r_inPkt[r] ? r_routePort[r]
                              : PW'(w_head[r].data[DII_DEST_WIDTH-1:0] - DII_DEST_WIDTH'(BASE_ID));
      w_fwdReq[r] = w_head[r].valid & ~w_local[r];
      for (int p = 0; p < PORTS; p++)
        w_locReq[r][p] = w_head[r].valid & w_local[r] & (w_port[r] == PW'(p));
    end
  end

  // Latch the route when a packet's first flit leaves, clear it on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inPkt      <= '0;
      r_routeLocal <= '0;
      for (int r = 0; r < RINGS; r++) r_routePort[r] <= '0;
    end else begin
      for (int r = 0; r < RINGS; r++) begin
        if (w_headPop[r]) begin
          r_inPkt[r]      <= ~w_head[r].last;
          r_routeLocal[r] <= w_local[r];
          r_routePort[r]  <= w_port[r];
        end
      end
    end
  end

  // A head flit leaves when its chosen output grants it and is ready.
  always_comb begin
    for (int r = 0; r < RINGS; r++) begin
      w_headPop[r] = w_fwdReq[r] & w_fwdGrant[r] & ring_out_ready[r];
      for (int p = 0; p < PORTS; p++)
        if (w_locReq[r][p] & w_locGrant[p][r] & dii_out_ready[p]) w_headPop[r] = 1'b1;
    end
  end

  for (genvar r = 0; r < RINGS; r++) begin : g_ringOut
    if (r == 0) begin : g_inject
      logic [PORTS:0] w_req, w_last, w_grant;
      dii_flit        w_out;
      // Requester 0 is ring forward traffic, requesters 1.. are local ports.
      always_comb begin
        w_req[0]  = w_fwdReq[0];
        w_last[0] = w_head[0].last;
        for (int p = 0; p < PORTS; p++) begin
          w_req[p+1]  = dii_in[p].valid & r_active;
          w_last[p+1] = dii_in[p].last;
        end
        w_out = '0;
        if (w_grant[0]) w_out = w_head[0];
        for (int p = 0; p < PORTS; p++)
          if (w_grant[p+1]) w_out = dii_in[p];
        w_out.valid = |(w_grant & w_req);
      end
      osd_rr_pkt_arbiter #(.N(PORTS + 1)) u_arb (
        .clk(clk), .rst(rst), .i_req(w_req), .i_last(w_last),
        .i_ready(ring_out_ready[0]), .o_grant(w_grant)
      );
      assign ring_out[0]   = w_out;
      assign w_fwdGrant[0] = w_grant[0];
      assign dii_in_ready  = w_grant[PORTS:1] & {PORTS{ring_out_ready[0] & r_active}};
    end else begin : g_forward
      logic [0:0] w_grant;
      osd_rr_pkt_arbiter #(.N(1)) u_arb (
        .clk(clk), .rst(rst), .i_req(w_fwdReq[r]), .i_last(w_head[r].last),
        .i_ready(ring_out_ready[r]), .o_grant(w_grant)
      );
      assign ring_out[r]   = {w_fwdReq[r] & w_grant[0], w_head[r].last, w_head[r].data};
      assign w_fwdGrant[r] = w_grant[0];
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_diiOut
    logic [RINGS-1:0] w_req, w_last, w_grant;
    dii_flit          w_out;
    // Local delivery competes among the rings addressing this port.
    always_comb begin
      w_out = '0;
      for (int r = 0; r < RINGS; r++) begin
        w_req[r]  = w_locReq[r][p];
        w_last[r] = w_head[r].last;
        if (w_grant[r]) w_out = w_head[r];
      end
      w_out.valid = |(w_grant & w_req);
    end
    osd_rr_pkt_arbiter #(.N(RINGS)) u_arb (
      .clk(clk), .rst(rst), .i_req(w_req), .i_last(w_last),
      .i_ready(dii_out_ready[p]), .o_grant(w_grant)
    );
    assign dii_out[p]    = w_out;
    assign w_locGrant[p] = w_grant;
  end

endmodule

// File: doc/osd_ring_router.md
OSD_RING_ROUTER -- requirements
Module: osd_ring_router

Interface
REQ-001 SHALL have parameter PORTS, default 4, meaning number of local debug modules attached (1..16).
REQ-002 SHALL have parameter RINGS, default 2, meaning number of ring channels (1..2).
REQ-003 SHALL have parameter BASE_ID, default 0, meaning 10-bit ID of local port 0; port p owns ID BASE_ID+p.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, meaning per-ring input FIFO depth in flits (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port ring_in, input, dii_flit[RINGS], incoming ring flits (valid, last, data[15:0]).
REQ-008 SHALL have port ring_in_ready, output, RINGS, ring input accept.
REQ-009 SHALL have port ring_out, output, dii_flit[RINGS], outgoing ring flits.
REQ-010 SHALL have port ring_out_ready, input, RINGS, downstream accept.
REQ-011 SHALL have port dii_in, input, dii_flit[PORTS], flits from local modules.
REQ-012 SHALL have port dii_in_ready, output, PORTS, local injection accept.
REQ-013 SHALL have port dii_out, output, dii_flit[PORTS], flits to local modules.
REQ-014 SHALL have port dii_out_ready, input, PORTS, local module accept.

Function
REQ-015 A flit SHALL transfer on any channel only in a cycle with valid=1 and ready=1; data, last SHALL hold while valid=1 and ready=0.
REQ-016 Each ring r SHALL buffer ring_in[r] in a BUF_DEPTH FIFO; ring_in_ready[r] = not full; simultaneous push and pop when full SHALL NOT be allowed (ready low when full).
REQ-017 First flit of a packet SHALL carry destination in data[9:0]; route SHALL be decided on that flit and held in a per-ring register until the flit with last=1 pops.
REQ-018 Destination in [BASE_ID, BASE_ID+PORTS-1] SHALL route to dii_out[dest-BASE_ID]; any other destination SHALL route to ring_out[r] unchanged (wrap-around of BASE_ID+p beyond 1023 SHALL NOT be supported; parameter check at elaboration).
REQ-019 FIFO head SHALL be presented combinationally; uncontested latency ring_in accept -> output valid SHALL be 1 cycle.
REQ-020 Local packets from dii_in SHALL be injected on ring_out[0] only; dii_in to ring_out[0] SHALL be combinational when granted.
REQ-021 Each output (ring_out[r], dii_out[p]) SHALL have a packet-atomic round-robin arbiter: state IDLE/LOCKED; in IDLE grant chosen combinationally from requesters starting after last winner; first flit transfers same cycle; move to LOCKED unless that flit has last=1; return to IDLE on transfer of last=1.
REQ-022 ring_out[0] requesters SHALL be ring-0 forward traffic (index 0) then ports 0..PORTS-1; dii_out[p] requesters SHALL be rings 0..RINGS-1.
REQ-023 Flits of two packets SHALL never interleave on any output.
REQ-024 dii_in_ready[p] SHALL be 1 only when port p holds/receives ring_out[0] grant and ring_out_ready[0]=1.
REQ-025 Single-flit packets (first flit last=1) SHALL not enter LOCKED.
REQ-026 Arbiter pointers SHALL advance only on completed packet grant.

Reset
REQ-027 While rst=1: all FIFOs empty, all arbiters IDLE, pointers 0, route registers cleared.
REQ-028 Reset values: ring_out[*].valid=0, dii_out[*].valid=0, ring_in_ready=0, dii_in_ready=0; ring_in_ready SHALL rise the first cycle after rst deasserts.
REQ-029 rst mid-packet SHALL discard partial packets; no remaining flits SHALL be emitted after reset.

Structure
REQ-030 dii_flit typedef SHALL remain in dii_package; add localparam DII_DEST_WIDTH=10 there.
REQ-031 One sub-module osd_rr_pkt_arbiter (N requesters, packet-atomic round-robin) SHALL be instantiated per output; FIFO SHALL use the existing dii_buffer-style flit FIFO.

Verification (PORTS=4, RINGS=2, BASE_ID=4, BUF_DEPTH=4)
REQ-032 ring_in[0] 3-flit packet dest 0x006 -> appears only on dii_out[2], in order, first flit 1 cycle after accept.
REQ-033 ring_in[1] packet dest 0x001 -> forwarded unchanged on ring_out[1]; no dii_out activity.
REQ-034 ports 0 and 3 inject 2-flit packets same cycle, ring idle -> ring_out[0] carries port 0 packet then port 3, no interleave; next contention port 1/3 grants port 3 first is wrong -> pointer resumes after port 3.
REQ-035 ring_out_ready[1]=0, ring_in[1] 5 non-local flits -> ring_in_ready[1]=0 after 4 accepted; ready released -> all 5 emitted in order.
REQ-036 both rings send packets to dest 0x005 same cycle -> dii_out[1] delivers ring 0 packet fully then ring 1.
REQ-037 rst pulsed during flit 2 of a 4-flit packet -> next cycle all valids 0, FIFOs empty, no trailing flits after release.
